spi_bus_bridge: RTL
===================

Name: spi_bus_bridge

Overview:
- Bus-side front end that sits directly upstream of spi_controller.
- Buffers CPU words in a TX FIFO and hands them one at a time to the controller's data_in/din_ready.
- Captures each returned data_out/dout_ready word into an RX FIFO.
- Owns the clkdiv register that drives the controller's divider.

Parameters:
DEPTH, 4, entries per FIFO (power of 2, min 2)
DW, 16, SPI word width (matches controller data_in/data_out)

Ports:
clock  in  1  system clock, all logic on rising edge
reset  in  1  asynchronous, active-low; logic resets while reset==0
sel  in  1  bus select
wen  in  1  write strobe (qualified by sel)
ren  in  1  read strobe (qualified by sel)
addr  in  4  byte address; 0x0 DATA, 0x4 STATUS, 0x8 CLKDIV, 0xC CTRL
wdata  in  32  write data
rdata  out  32  read data, registered
data_in  out  DW  word to controller
din_ready  out  1  one-cycle start strobe to controller
data_out  in  DW  word from controller
dout_ready  in  1  controller transfer-complete strobe
clkdiv  out  32  divider value to controller
irq  out  1  high while RX FIFO non-empty

Behaviour:
- Reset (reset==0, async): both FIFOs empty, pointers 0, FSM IDLE, sticky flags 0.
- Reset values of outputs: rdata=0, data_in=0, din_ready=0, clkdiv=0, irq=0.
- Reset mid-transfer abandons the word silently.
- Writes (sel&wen):
  - DATA: push wdata[DW-1:0] to TX. If TX full: word dropped, tx_ovf<=1.
  - CLKDIV: clkdiv<=wdata.
  - STATUS: write-1-to-clear bits 5,6.
  - CTRL: bit0=1 flushes both FIFOs and forces FSM to IDLE with din_ready=0; a dout_ready in the same cycle is discarded.
- Reads (sel&ren): rdata is updated on the next edge with the addressed value and held until the next read.
  - DATA: pop RX. If RX empty: rdata=0, no pop.
  - STATUS: [0] tx_empty, [1] tx_full, [2] rx_empty, [3] rx_full, [4] busy (FSM!=IDLE), [5] tx_ovf, [6] rx_ovf, [31:7] 0.
  - CLKDIV: current value.
  - CTRL: reads 0.
  - Unmapped addresses read 0 and ignore writes.
- FSM:
  - IDLE: TX non-empty -> ISSUE.
  - ISSUE (1 cycle): data_in<=TX head, din_ready=1, pop TX -> WAIT.
  - WAIT: dout_ready=1 -> push data_out to RX -> IDLE. data_in held stable throughout WAIT.
- Latency: a DATA write accepted on edge E with FSM in IDLE and TX empty gives din_ready high for exactly the cycle after edge E+1.
- Back-to-back: minimum 1 IDLE cycle between dout_ready and the next din_ready.
- dout_ready outside WAIT: ignored, no RX push.
- RX push when full: word dropped, rx_ovf<=1, FSM still returns to IDLE.
- Simultaneous events:
  - TX bus push + FSM pop in the same cycle: both occur, including when TX is full (push accepted, no ovf).
  - RX same rule: pop and push in the same cycle both occur.
- Pointers are log2(DEPTH)+1 bits; full/empty from the MSB compare; wrap is natural modulo.
- irq = ~rx_empty, registered state only, no combinational path from bus.

Test Plan:
- Reset then read STATUS -> 0x0000_0005; clkdiv=0, din_ready=0.
- Write DATA=0xA5A5 at edge E -> din_ready high for exactly one cycle after E+1, data_in=0xA5A5; drive dout_ready with data_out=0x5A5A -> irq=1; read DATA -> 0x5A5A, then STATUS bit2=1.
- Hold dout_ready low and write 6 words with DEPTH=4 (1 issued, 4 queued) -> 6th write dropped, STATUS bit5=1, bit1=1; write STATUS 0x20 -> bit5=0.
- Never read RX; complete 5 transfers -> 5th returned word dropped, rx_ovf=1; read 4 words in order; 5th read -> 0.
- Mid-WAIT: write CTRL=1 while pulsing dout_ready the same cycle -> FIFOs empty, busy=0, no RX push, no further din_ready.
- Assert reset low mid-WAIT, asynchronously between edges -> all outputs reset immediately; after release, data_in=0 and no stray din_ready.

Source files
------------

// File: rtl/spi_bus_bridge.sv
// Bus-side front end for spi_controller: TX/RX word FIFOs, the clkdiv register
// and a small sequencer that issues one TX word at a time and collects replies.
module spi_bus_bridge #(
    parameter int DEPTH = 4,
    parameter int DW    = 16
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          sel,
    input  logic          wen,
    input  logic          ren,
    input  logic [3:0]    addr,
    input  logic [31:0]   wdata,
    output logic [31:0]   rdata,
    output logic [DW-1:0] data_in,
    output logic          din_ready,
    input  logic [DW-1:0] data_out,
    input  logic          dout_ready,
    output logic [31:0]   clkdiv,
    output logic          irq
);

    localparam int AW = $clog2(DEPTH);
    localparam int PW = AW + 1;
    localparam logic [PW-1:0] PTR_ONE = PW'(1);

    typedef enum logic [1:0] {ST_IDLE, ST_ISSUE, ST_WAIT} state_t;

    state_t state, state_nxt;

    logic [DW-1:0] tx_mem [DEPTH];
    logic [DW-1:0] rx_mem [DEPTH];
    logic [PW-1:0] tx_wp, tx_rp, rx_wp, rx_rp;
    logic          tx_ovf, rx_ovf;

    logic wr_en, rd_en;
    logic wr_data, wr_status, wr_clkdiv, flush, rd_data;
    logic tx_empty, tx_full, rx_empty, rx_full;
    logic tx_pop, tx_push, rx_pop, rx_req, rx_push;
    logic [31:0] status, rd_val;

    function automatic logic ptr_full(input logic [PW-1:0] wp, input logic [PW-1:0] rp);
        return (wp[PW-1] != rp[PW-1]) && (wp[AW-1:0] == rp[AW-1:0]);
    endfunction

    function automatic logic [31:0] zext(input logic [DW-1:0] w);
        logic [31:0] r;
        r = '0;
        r[DW-1:0] = w;
        return r;
    endfunction

    assign wr_en     = sel & wen;
    assign rd_en     = sel & ren;
    assign wr_data   = wr_en && (addr == 4'h0);
    assign wr_status = wr_en && (addr == 4'h4);
    assign wr_clkdiv = wr_en && (addr == 4'h8);
    assign flush     = wr_en && (addr == 4'hC) && wdata[0];
    assign rd_data   = rd_en && (addr == 4'h0);

    assign tx_empty = (tx_wp == tx_rp);
    assign rx_empty = (rx_wp == rx_rp);
    assign tx_full  = ptr_full(tx_wp, tx_rp);
    assign rx_full  = ptr_full(rx_wp, rx_rp);

    // A full FIFO still accepts a push when it is being popped on the same edge.
    assign tx_push = wr_data && (!tx_full || tx_pop);
    assign rx_pop  = rd_data && !rx_empty;
    assign rx_push = rx_req && (!rx_full || rx_pop);

    assign status = {25'd0, rx_ovf, tx_ovf, (state != ST_IDLE),
                     rx_full, rx_empty, tx_full, tx_empty};

    assign irq = !rx_empty;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) state <= ST_IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        tx_pop    = 1'b0;
        rx_req    = 1'b0;
        case (state)
            ST_IDLE: begin
                if (!tx_empty) begin
                    state_nxt = ST_ISSUE;
                    tx_pop    = 1'b1;
                end
            end
            ST_ISSUE: state_nxt = ST_WAIT;
            ST_WAIT: begin
                if (dout_ready) begin
                    rx_req    = 1'b1;
                    state_nxt = ST_IDLE;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
        // Flush overrides the sequencer and swallows a coincident reply.
        if (flush) begin
            state_nxt = ST_IDLE;
            tx_pop    = 1'b0;
            rx_req    = 1'b0;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            tx_wp <= '0;
            tx_rp <= '0;
            rx_wp <= '0;
            rx_rp <= '0;
        end else if (flush) begin
            tx_wp <= '0;
            tx_rp <= '0;
            rx_wp <= '0;
            rx_rp <= '0;
        end else begin
            if (tx_push) tx_wp <= tx_wp + PTR_ONE;
            if (tx_pop)  tx_rp <= tx_rp + PTR_ONE;
            if (rx_push) rx_wp <= rx_wp + PTR_ONE;
            if (rx_pop)  rx_rp <= rx_rp + PTR_ONE;
        end
    end

    always_ff @(posedge clock) begin
        if (tx_push && !flush) tx_mem[tx_wp[AW-1:0]] <= wdata[DW-1:0];
        if (rx_push)           rx_mem[rx_wp[AW-1:0]] <= data_out;
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            tx_ovf <= 1'b0;
            rx_ovf <= 1'b0;
        end else begin
            if (wr_status && wdata[5]) tx_ovf <= 1'b0;
            if (wr_status && wdata[6]) rx_ovf <= 1'b0;
            if (wr_data && !tx_push)   tx_ovf <= 1'b1;
            if (rx_req && !rx_push)    rx_ovf <= 1'b1;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset)         clkdiv <= '0;
        else if (wr_clkdiv) clkdiv <= wdata;
    end

    always_comb begin
        rd_val = '0;
        case (addr)
            4'h0:    rd_val = rx_empty ? 32'd0 : zext(rx_mem[rx_rp[AW-1:0]]);
            4'h4:    rd_val = status;
            4'h8:    rd_val = clkdiv;
            default: rd_val = '0;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset)     rdata <= '0;
        else if (rd_en) rdata <= rd_val;
    end

    // The word is latched as the strobe rises so data_in is valid with
    // din_ready and stays put for the whole wait.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            data_in   <= '0;
            din_ready <= 1'b0;
        end else begin
            din_ready <= tx_pop;
            if (tx_pop) data_in <= tx_mem[tx_rp[AW-1:0]];
        end
    end

endmodule
